// File: rtl/verificador_pkg.sv
// rtl/verificador_pkg.sv - shared state encoding and defaults for the verificador_n checker
package verificador_pkg;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  localparam int LAT_MAX   = 7;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  // Delay depths above LAT_MAX are clamped so the chain and the settle count agree.
  function automatic int lat_clamp(input int lat);
    return (lat > LAT_MAX) ? LAT_MAX : lat;
  endfunction

endpackage

// File: rtl/verif_delay_line.sv
// rtl/verif_delay_line.sv - EN-gated register chain that aligns Qc to Qe; LAT = 0 is a wire
module verif_delay_line
  import verificador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LAT   = 2
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  localparam int DEPTH = lat_clamp(LAT);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign Q = D;
    end else begin : g_chain
      logic [WIDTH-1:0] pipe_q [DEPTH];
      logic [WIDTH-1:0] pipe_d [DEPTH];

      always_comb begin
        pipe_d = pipe_q;
        if (EN) begin
          pipe_d[0] = D;
          for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge CLK) begin
        if (!RESET_L) begin
          for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign Q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/verificador_n.sv
// rtl/verificador_n.sv - cycle-aligned Qe/Qc equivalence checker with sticky alert and error count
// Optional first-mismatch capture ports: VERIFICADOR_N_CAPTURE_EN
module verificador_n
  import verificador_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LAT    = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             EN,
  input  logic             CLEAR,
  input  logic [WIDTH-1:0] Qe,
  input  logic [WIDTH-1:0] Qc,
  output logic             ALERTA,
  output logic             ALERTA_STICKY,
  output logic             CHECKING,
  output logic [CNT_W-1:0] ERR_CNT
`ifdef VERIFICADOR_N_CAPTURE_EN
  ,
  output logic [CNT_W-1:0] FIRST_CYC,
  output logic [WIDTH-1:0] FIRST_MASK
`endif
);

  localparam int          LAT_EFF    = lat_clamp(LAT);
  localparam logic [31:0] SETTLE_TOT = 32'(SETTLE + LAT_EFF);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [31:0]      scnt_q, scnt_d;
  logic             alerta_q, alerta_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
`ifdef VERIFICADOR_N_CAPTURE_EN
  logic [CNT_W-1:0] first_cyc_q, first_cyc_d;
  logic [WIDTH-1:0] first_mask_q, first_mask_d;
`endif

  logic [WIDTH-1:0] qc_dly;
  logic             mism;
  logic             check_edge;

  verif_delay_line #(.WIDTH(WIDTH), .LAT(LAT_EFF)) u_dly (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .EN      (EN),
    .D       (Qc),
    .Q       (qc_dly)
  );

  always_comb begin
    // 4-state compare: differing X/Z bits count as a mismatch.
    mism       = (Qe !== qc_dly);
    check_edge = (state_q == ST_CHECK) && EN;
    state_d    = state_q;
    scnt_d     = scnt_q;
    alerta_d   = check_edge && mism;
    sticky_d   = sticky_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
`ifdef VERIFICADOR_N_CAPTURE_EN
    first_cyc_d  = first_cyc_q;
    first_mask_d = first_mask_q;
`endif

    if (state_q == ST_SETTLE) begin
      if (SETTLE_TOT == 32'd0) begin
        state_d = ST_CHECK;
      end else if (EN) begin
        scnt_d = scnt_q + 32'd1;
        if (scnt_d == SETTLE_TOT) state_d = ST_CHECK;
      end
    end

    if (check_edge) begin
      if (cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
      if (mism) begin
`ifdef VERIFICADOR_N_CAPTURE_EN
        if (!sticky_q) begin
          first_cyc_d  = cyc_q;
          first_mask_d = Qe ^ qc_dly;
        end
`endif
        sticky_d = 1'b1;
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
      end
    end

    if (CLEAR) begin
      sticky_d = 1'b0;
      err_d    = '0;
      cyc_d    = '0;
`ifdef VERIFICADOR_N_CAPTURE_EN
      first_cyc_d  = '0;
      first_mask_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q  <= ST_SETTLE;
      scnt_q   <= '0;
      alerta_q <= 1'b0;
      sticky_q <= 1'b0;
      err_q    <= '0;
      cyc_q    <= '0;
`ifdef VERIFICADOR_N_CAPTURE_EN
      first_cyc_q  <= '0;
      first_mask_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      alerta_q <= alerta_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
`ifdef VERIFICADOR_N_CAPTURE_EN
      first_cyc_q  <= first_cyc_d;
      first_mask_q <= first_mask_d;
`endif
    end
  end

  assign ALERTA        = alerta_q;
  assign ALERTA_STICKY = sticky_q;
  assign CHECKING      = (state_q == ST_CHECK);
  assign ERR_CNT       = err_q;
`ifdef VERIFICADOR_N_CAPTURE_EN
  assign FIRST_CYC     = first_cyc_q;
  assign FIRST_MASK    = first_mask_q;
`endif

endmodule

// File: tb/tb_verificador_n.sv
// tb/tb_verificador_n.sv - randomized scoreboard bench for verificador_n (CNT_W 16 and 4 copies)
module tb_verificador_n;

  localparam int WIDTH  = 32;
  localparam int LAT    = 2;
  localparam int SETTLE = 1;
  localparam int TOT    = SETTLE + LAT;

  logic        CLK = 1'b0;
  logic        RESET_L = 1'b0;
  logic        EN = 1'b0;
  logic        CLEAR = 1'b0;
  logic [31:0] Qe = '0;
  logic [31:0] Qc = '0;

  logic        alerta, sticky, checking;
  logic [15:0] err_cnt;
  logic        alerta4, sticky4, checking4;
  logic [3:0]  err_cnt4;
`ifdef VERIFICADOR_N_CAPTURE_EN
  logic [15:0] first_cyc;
  logic [31:0] first_mask;
  logic [3:0]  first_cyc4;
  logic [31:0] first_mask4;
`endif

  always #5 CLK = ~CLK;

  verificador_n #(.WIDTH(WIDTH), .LAT(LAT), .SETTLE(SETTLE), .CNT_W(16)) u_dut (
    .CLK(CLK), .RESET_L(RESET_L), .EN(EN), .CLEAR(CLEAR), .Qe(Qe), .Qc(Qc),
    .ALERTA(alerta), .ALERTA_STICKY(sticky), .CHECKING(checking), .ERR_CNT(err_cnt)
`ifdef VERIFICADOR_N_CAPTURE_EN
    , .FIRST_CYC(first_cyc), .FIRST_MASK(first_mask)
`endif
  );

  verificador_n #(.WIDTH(WIDTH), .LAT(LAT), .SETTLE(SETTLE), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RESET_L(RESET_L), .EN(EN), .CLEAR(CLEAR), .Qe(Qe), .Qc(Qc),
    .ALERTA(alerta4), .ALERTA_STICKY(sticky4), .CHECKING(checking4), .ERR_CNT(err_cnt4)
`ifdef VERIFICADOR_N_CAPTURE_EN
    , .FIRST_CYC(first_cyc4), .FIRST_MASK(first_mask4)
`endif
  );

  typedef struct {
    logic        alerta;
    logic        sticky;
    logic        checking;
    logic [15:0] err16;
    logic [3:0]  err4;
    logic [15:0] fcyc16;
    logic [3:0]  fcyc4;
    logic [31:0] fmask;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: Qc history of EN edges, raw counters saturated only when reported.
  logic [31:0] m_hist[$];
  int          m_en_edges;
  bit          m_sticky;
  int          m_err, m_cyc, m_fcyc;
  logic [31:0] m_fmask;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] aligned();
    return m_hist[0];
  endfunction

  task automatic model_reset();
    m_hist = {};
    repeat (LAT) m_hist.push_back(32'h0);
    m_en_edges = 0;
    m_sticky   = 0;
    m_err      = 0;
    m_cyc      = 0;
    m_fcyc     = 0;
    m_fmask    = '0;
  endtask

  task automatic step(input logic rl, input logic en, input logic clr,
                      input logic [31:0] qe, input logic [31:0] qc);
    exp_t        e;
    logic [31:0] qcd;
    bit          chk, mm;
    @(negedge CLK);
    RESET_L = rl; EN = en; CLEAR = clr; Qe = qe; Qc = qc;
    e.alerta = 1'b0;
    if (!rl) begin
      model_reset();
    end else begin
      qcd = aligned();
      mm  = (qe !== qcd);
      chk = (m_en_edges >= TOT) && en;
      e.alerta = chk && mm;
      if (chk && mm) begin
        if (!m_sticky) begin
          m_fcyc  = m_cyc;
          m_fmask = qe ^ qcd;
        end
        m_sticky = 1;
        m_err++;
      end
      if (chk) m_cyc++;
      if (clr) begin
        m_sticky = 0; m_err = 0; m_cyc = 0; m_fcyc = 0; m_fmask = '0;
      end
      if (en) begin
        m_hist.push_back(qc);
        void'(m_hist.pop_front());
        m_en_edges++;
      end
    end
    e.sticky   = m_sticky;
    e.checking = (m_en_edges >= TOT);
    e.err16    = 16'(sat(m_err, 65535));
    e.err4     = 4'(sat(m_err, 15));
    e.fcyc16   = 16'(sat(m_fcyc, 65535));
    e.fcyc4    = 4'(sat(m_fcyc, 15));
    e.fmask    = m_fmask;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alerta",    32'(alerta),    32'(e.alerta));
        chk("sticky",    32'(sticky),    32'(e.sticky));
        chk("checking",  32'(checking),  32'(e.checking));
        chk("err_cnt",   32'(err_cnt),   32'(e.err16));
        chk("alerta4",   32'(alerta4),   32'(e.alerta));
        chk("sticky4",   32'(sticky4),   32'(e.sticky));
        chk("checking4", 32'(checking4), 32'(e.checking));
        chk("err_cnt4",  32'(err_cnt4),  32'(e.err4));
`ifdef VERIFICADOR_N_CAPTURE_EN
        chk("first_cyc",   32'(first_cyc),  32'(e.fcyc16));
        chk("first_mask",  first_mask,      e.fmask);
        chk("first_cyc4",  32'(first_cyc4), 32'(e.fcyc4));
        chk("first_mask4", first_mask4,     e.fmask);
`endif
      end
    end
  end

  initial begin : driver
    logic [31:0] k;
    logic [31:0] qe, xv;
    bit          en, flipped;
    k = '0;
    flipped = 0;
    model_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, '0, '0);

    // Aligned counting stream, one bit-5 flip at check index 10, EN low for 5 cycles.
    for (int i = 0; i < 100; i++) begin
      en = !(i >= 40 && i < 45);
      if (en) begin
        qe = aligned();
        if (!flipped && m_en_edges >= TOT && m_cyc == 10) begin
          qe = qe ^ 32'h0000_0020;
          flipped = 1;
        end
        step(1'b1, 1'b1, 1'b0, qe, k);
        k++;
      end else begin
        step(1'b1, 1'b0, 1'b0, $urandom, $urandom);
      end
    end

    // Upper half X/Z against a zero-aligned Qc.
    xv = 32'hxxxx_0000;
    repeat (2) step(1'b1, 1'b1, 1'b0, aligned(), 32'h0);
    step(1'b1, 1'b1, 1'b0, xv, 32'h0);

    // Persistent mismatch saturates the 4-bit counter; CLEAR pulsed mid-stream.
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, (i == 22), ~aligned(), k);
      k++;
    end

    // Randomized EN, CLEAR and bit flips.
    for (int i = 0; i < 150; i++) begin
      en = ($urandom_range(0, 9) < 8);
      qe = aligned();
      if ($urandom_range(0, 9) == 0) qe = qe ^ (32'h1 << $urandom_range(0, 31));
      if (!en) qe = $urandom;
      step(1'b1, en, ($urandom_range(0, 19) == 0), qe, $urandom);
    end

    // One-cycle reset mid-CHECK, then the settle sequence again with a flip.
    step(1'b0, 1'b1, 1'b0, $urandom, $urandom);
    for (int i = 0; i < 20; i++) begin
      qe = aligned();
      if (i == 8) qe = qe ^ 32'h8000_0001;
      step(1'b1, 1'b1, 1'b0, qe, $urandom);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    #2;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
